// File: rtl/wb_filter_ram_responder.sv
// Wishbone classic slave that serves a word RAM with configurable wait states and a side preload port.
// Define WB_RESP_ERR_EN to answer out-of-range accesses with wb_err; otherwise the index wraps modulo DEPTH.
module wb_filter_ram_responder #(
  parameter logic [29:0] BASE_WORD   = 30'h0,
  parameter int          DEPTH       = 128,
  parameter int          WAIT_STATES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [29:0]              wb_adr,
  input  logic [31:0]              wb_dat_mosi,
  input  logic [3:0]               wb_sel,
  input  logic                     wb_cyc,
  input  logic                     wb_stb,
  input  logic                     wb_we,
  input  logic [2:0]               wb_cti,
  input  logic [1:0]               wb_bte,
  output logic [31:0]              wb_dat_miso,
  output logic                     wb_ack,
  output logic                     wb_err,
  input  logic                     pre_we,
  input  logic [$clog2(DEPTH)-1:0] pre_addr,
  input  logic [31:0]              pre_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [29:0] adr_reg;
  logic        we_reg;
  logic [3:0]  sel_reg;
  logic [31:0] dat_reg;
  logic [2:0]  wait_cnt_reg;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic [29:0] offset;
  logic [AW-1:0] idx;
  logic        out_of_range;
  logic        bus_commit;
  logic [31:0] byte_mask;

  assign accept = wb_cyc & wb_stb;
  // Unsigned subtraction: addresses below BASE_WORD wrap to huge offsets and fall out of range.
  assign offset = adr_reg - BASE_WORD;
  assign idx    = offset[AW-1:0];

`ifdef WB_RESP_ERR_EN
  assign out_of_range = (offset >= 30'(DEPTH));
  logic unused_bits;
  assign unused_bits = ^{wb_cti, wb_bte};
`else
  assign out_of_range = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{wb_cti, wb_bte, offset[29:AW]};
`endif

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
      assign byte_mask[gi*8 +: 8] = {8{sel_reg[gi]}};
    end
  endgenerate

  assign bus_commit = (state_reg == RESP) && we_reg && !out_of_range;

  // State and request registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 3'd0;
      adr_reg      <= 30'd0;
      we_reg       <= 1'b0;
      sel_reg      <= 4'd0;
      dat_reg      <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && accept) begin
        adr_reg <= wb_adr;
        we_reg  <= wb_we;
        sel_reg <= wb_sel;
        dat_reg <= wb_dat_mosi;
      end
      if (state_reg == WAIT) wait_cnt_reg <= wait_cnt_reg + 3'd1;
      else                   wait_cnt_reg <= 3'd0;
    end
  end

  // Preload is written last so it overrides a bus write to the same word on the same edge.
  always_ff @(posedge clk) begin
    if (bus_commit) mem[idx] <= (mem[idx] & ~byte_mask) | (dat_reg & byte_mask);
    if (pre_we)     mem[pre_addr] <= pre_data;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT: begin
        if (!wb_cyc)                      state_next = IDLE;
        else if (wait_cnt_reg == WS_LAST) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read is combinational from the array so RESP sees the word as it stood before this edge's writes.
  always_comb begin
    wb_ack      = 1'b0;
    wb_err      = 1'b0;
    wb_dat_miso = 32'h0;
    if (state_reg == RESP) begin
      if (out_of_range) begin
        wb_err = 1'b1;
      end else begin
        wb_ack = 1'b1;
        if (!we_reg) wb_dat_miso = mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_filter_ram_responder.sv
// Directed bench for wb_filter_ram_responder: vector table plus hand-written multi-cycle sequences.
// A second instance with WAIT_STATES=3 covers the abort path and the longer latency.
module tb_wb_filter_ram_responder;

`ifdef WB_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [29:0] wb_adr = '0;
  logic [31:0] wb_dat_mosi = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic        cyc3 = 1'b0, stb3 = 1'b0;
  logic [2:0]  wb_cti = 3'b000;
  logic [1:0]  wb_bte = 2'b00;
  logic [31:0] wb_dat_miso, dat3;
  logic        wb_ack, wb_err, ack3, err3;
  logic        pre_we = 1'b0;
  logic [6:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_filter_ram_responder dut (
    .clk(clk), .reset(reset), .wb_adr(wb_adr), .wb_dat_mosi(wb_dat_mosi), .wb_sel(wb_sel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_cti(wb_cti), .wb_bte(wb_bte),
    .wb_dat_miso(wb_dat_miso), .wb_ack(wb_ack), .wb_err(wb_err),
    .pre_we(pre_we), .pre_addr(pre_addr), .pre_data(pre_data)
  );

  wb_filter_ram_responder #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .wb_adr(wb_adr), .wb_dat_mosi(wb_dat_mosi), .wb_sel(wb_sel),
    .wb_cyc(cyc3), .wb_stb(stb3), .wb_we(wb_we), .wb_cti(wb_cti), .wb_bte(wb_bte),
    .wb_dat_miso(dat3), .wb_ack(ack3), .wb_err(err3),
    .pre_we(pre_we), .pre_addr(pre_addr), .pre_data(pre_data)
  );

  typedef struct {
    bit          we;
    logic [29:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    bit          exp_ack;
    bit          exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [6:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Counts falling edges until the default instance acks or errs; 0 means timeout.
  task automatic wait_resp(output int n);
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (wb_ack | wb_err) begin n = c; break; end
    end
  endtask

  // Called on a falling edge; returns on the falling edge of the following idle cycle.
  task automatic bus_txn(input bit use3, input bit we, input logic [29:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output logic ack, output logic err,
                         output logic [31:0] rd, output int lat);
    wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_mosi = dat;
    if (use3) begin cyc3 = 1'b1; stb3 = 1'b1; end
    else      begin wb_cyc = 1'b1; wb_stb = 1'b1; end
    ack = 1'b0; err = 1'b0; rd = '0; lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (use3 ? (ack3 | err3) : (wb_ack | wb_err)) begin
        ack = use3 ? ack3 : wb_ack;
        err = use3 ? err3 : wb_err;
        rd  = use3 ? dat3 : wb_dat_miso;
        lat = c;
        break;
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic        a, e;
    logic [31:0] d;
    int          lat, n;

    vecs[0]  = '{0, 30'd5,   4'hF, 32'h0,        1, 0, 32'h01FF7F80};
    vecs[1]  = '{1, 30'd3,   4'h5, 32'h11223344, 1, 0, 32'h0};
    vecs[2]  = '{0, 30'd3,   4'hF, 32'h0,        1, 0, 32'hAA22CC44};
    vecs[3]  = '{1, 30'd0,   4'hF, 32'hDEADBEEF, 1, 0, 32'h0};
    vecs[4]  = '{0, 30'd0,   4'hF, 32'h0,        1, 0, 32'hDEADBEEF};
    vecs[5]  = '{1, 30'd127, 4'h8, 32'h12345678, 1, 0, 32'h0};
    vecs[6]  = '{0, 30'd127, 4'hF, 32'h0,        1, 0, 32'h12654321};
    vecs[7]  = '{0, 30'd200, 4'hF, 32'h0,        !ERR_EN, ERR_EN, ERR_EN ? 32'h0 : 32'hCAFE0072};
    vecs[8]  = '{1, 30'd138, 4'hF, 32'h55555555, !ERR_EN, ERR_EN, 32'h0};
    vecs[9]  = '{0, 30'd10,  4'hF, 32'h0,        1, 0, ERR_EN ? 32'h0A0A0A0A : 32'h55555555};
    vecs[10] = '{1, 30'd5,   4'h0, 32'hFFFFFFFF, 1, 0, 32'h0};
    vecs[11] = '{0, 30'd5,   4'hF, 32'h0,        1, 0, 32'h01FF7F80};
    vecs[12] = '{0, 30'd128, 4'hF, 32'h0,        !ERR_EN, ERR_EN, ERR_EN ? 32'h0 : 32'hDEADBEEF};

    // Reset state
    #3;
    check("reset_ack", {31'b0, wb_ack}, 32'h0);
    check("reset_err", {31'b0, wb_err}, 32'h0);
    check("reset_dat", wb_dat_miso, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    preload(7'd5,   32'h01FF7F80);
    preload(7'd3,   32'hAABBCCDD);
    preload(7'd72,  32'hCAFE0072);
    preload(7'd127, 32'h87654321);
    preload(7'd10,  32'h0A0A0A0A);
    preload(7'd9,   32'h99999999);
    preload(7'd7,   32'h77777777);
    preload(7'd4,   32'h44444444);

    for (int i = 0; i < 13; i++) begin
      bus_txn(0, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdat, a, e, d, lat);
      $display("vec %0d we=%0b adr=%0d sel=%h ack=%0b err=%0b dat=%h lat=%0d",
               i, vecs[i].we, vecs[i].adr, vecs[i].sel, a, e, d, lat);
      check($sformatf("vec%0d_ack", i), {31'b0, a}, {31'b0, vecs[i].exp_ack});
      check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_dat", i), d, vecs[i].exp_dat);
      check($sformatf("vec%0d_lat", i), lat, 32'd2);
    end

    // Back-to-back: strobe stays high through RESP, next request taken in the following idle cycle
    wb_we = 1'b0; wb_adr = 30'd5; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
    wait_resp(n);
    check("b2b_first_lat", n, 32'd2);
    check("b2b_first_dat", wb_dat_miso, 32'h01FF7F80);
    wb_adr = 30'd3;
    wait_resp(n);
    check("b2b_second_lat", n, 32'd3);
    check("b2b_second_dat", wb_dat_miso, 32'hAA22CC44);
    $display("b2b second read adr=3 dat=%h after %0d cycles", wb_dat_miso, n);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);

    // Read of word 7 in RESP while a preload hits it on the closing edge
    wb_we = 1'b0; wb_adr = 30'd7; wb_cyc = 1'b1; wb_stb = 1'b1;
    wait_resp(n);
    pre_we = 1'b1; pre_addr = 7'd7; pre_data = 32'h33333333;
    #1;
    check("rd_vs_preload_old", wb_dat_miso, 32'h01FF7F80 ^ 32'h01FF7F80 ^ 32'h77777777);
    $display("read w7 during preload dat=%h", wb_dat_miso);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    pre_we = 1'b0;
    bus_txn(0, 0, 30'd7, 4'hF, 32'h0, a, e, d, lat);
    check("rd_after_preload", d, 32'h33333333);

    // Bus write and preload to word 7 on the same edge
    wb_we = 1'b1; wb_adr = 30'd7; wb_sel = 4'hF; wb_dat_mosi = 32'h1; wb_cyc = 1'b1; wb_stb = 1'b1;
    wait_resp(n);
    pre_we = 1'b1; pre_addr = 7'd7; pre_data = 32'h2;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    pre_we = 1'b0;
    bus_txn(0, 0, 30'd7, 4'hF, 32'h0, a, e, d, lat);
    $display("collision w7 read back dat=%h", d);
    check("collision_preload_wins", d, 32'h2);

    // Abort: WAIT_STATES=3 write, cyc dropped in the second wait cycle
    wb_we = 1'b1; wb_adr = 30'd4; wb_sel = 4'hF; wb_dat_mosi = 32'hFFFFFFFF; cyc3 = 1'b1; stb3 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cyc3 = 1'b0; stb3 = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack3 | err3) n++;
    end
    check("abort_no_resp", n, 32'd0);
    bus_txn(1, 0, 30'd4, 4'hF, 32'h0, a, e, d, lat);
    $display("ws3 read after abort ack=%0b dat=%h lat=%0d", a, d, lat);
    check("abort_mem_kept", d, 32'h44444444);
    check("ws3_ack", {31'b0, a}, 32'h1);
    check("ws3_lat", lat, 32'd4);

    // Reset asserted while a write to word 9 sits in WAIT
    wb_we = 1'b1; wb_adr = 30'd9; wb_sel = 4'hF; wb_dat_mosi = 32'h0; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_wait_ack", {31'b0, wb_ack}, 32'h0);
    check("rst_wait_err", {31'b0, wb_err}, 32'h0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_txn(0, 0, 30'd9, 4'hF, 32'h0, a, e, d, lat);
    $display("read w9 after reset-in-wait ack=%0b dat=%h lat=%0d", a, d, lat);
    check("rst_mem9_kept", d, 32'h99999999);
    check("rst_next_lat", lat, 32'd2);

    // Reset asserted during RESP drops ack and data without waiting for a clock
    wb_we = 1'b0; wb_adr = 30'd5; wb_cyc = 1'b1; wb_stb = 1'b1;
    wait_resp(n);
    check("resp_ack_before_rst", {31'b0, wb_ack}, 32'h1);
    reset = 1'b0;
    #1;
    check("rst_async_ack", {31'b0, wb_ack}, 32'h0);
    check("rst_async_dat", wb_dat_miso, 32'h0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_filter_ram_responder.md
WB_FILTER_RAM_RESPONDER -- requirements
Module: wb_filter_ram_responder

Interface
REQ-001 Parameters SHALL be, one per line:
  BASE_WORD, 30'h0, word address of entry 0.
  DEPTH, 128, words held; power of two, 16..1024.
  WAIT_STATES, 1, extra cycles before ack; range 0..7.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all logic rising-edge.
  reset  in  1  asynchronous, active-low reset.
  wb_adr  in  30  word address.
  wb_dat_mosi  in  32  write data.
  wb_sel  in  4  byte enables; bit n selects byte n.
  wb_cyc  in  1  bus cycle active.
  wb_stb  in  1  strobe.
  wb_we  in  1  1 = write, 0 = read.
  wb_cti  in  3  cycle type; ignored, classic only.
  wb_bte  in  2  burst type; ignored.
  wb_dat_miso  out  32  read data.
  wb_ack  out  1  normal termination.
  wb_err  out  1  error termination.
  pre_we  in  1  preload write strobe.
  pre_addr  in  log2(DEPTH)  preload word index.
  pre_data  in  32  preload data, full word.
REQ-003 Clock SHALL be clk; reset SHALL be asynchronous and active-low on port reset (asserted when 0).

Function
REQ-004 FSM states SHALL be IDLE, WAIT, RESP.
REQ-005 IDLE: when wb_cyc&wb_stb, latch adr/we/sel/mosi; go to WAIT if WAIT_STATES>0, else RESP.
REQ-006 WAIT: count WAIT_STATES cycles, then go to RESP.
REQ-007 RESP: assert wb_ack or wb_err for exactly one cycle, then go to IDLE.
REQ-008 Latency: ack/err SHALL be high WAIT_STATES+1 cycles after the accepting edge.
REQ-009 Index SHALL be wb_adr-BASE_WORD; the access is in range when 0 <= index < DEPTH.
REQ-010 Read in RESP SHALL drive wb_dat_miso = mem[index]; otherwise wb_dat_miso SHALL be 32'h0.
REQ-011 Write SHALL commit only in the RESP cycle, and only the bytes whose wb_sel bit is 1.
REQ-012 When wb_cyc drops in WAIT, the block SHALL abort to IDLE: no ack, no err, no write.
REQ-013 wb_cyc&wb_stb still high in the IDLE cycle after RESP SHALL be accepted as a new request (back-to-back).
REQ-014 pre_we SHALL write pre_data to mem[pre_addr] on that edge in any state.
REQ-015 When a preload and a bus write commit to the same word on the same edge, the preload SHALL win.
REQ-016 A read in RESP of a word being preloaded on that edge SHALL return the old value.
REQ-017 wb_ack and wb_err SHALL never be high together.

Reset
REQ-018 While reset=0: state IDLE, wait counter 0, wb_ack=0, wb_err=0, wb_dat_miso=0, immediately (asynchronous).
REQ-019 Memory contents SHALL NOT be cleared by reset.
REQ-020 A transaction in flight at reset assertion SHALL be dropped, with no write commit.

Configuration
REQ-021 Macro WB_RESP_ERR_EN:
  Defined: an out-of-range access SHALL terminate with wb_err, write no memory, and return 0.
  Undefined: index SHALL wrap modulo DEPTH, the access terminates with wb_ack, and wb_err SHALL be tied 0.

Verification
REQ-022 Default params, preload mem[5]=32'h01FF7F80, read wb_adr=5 -> wb_ack exactly 2 cycles after accept, wb_dat_miso=32'h01FF7F80.
REQ-023 mem[3]=32'hAABBCCDD, write 32'h11223344 with sel=4'b0101, then read -> 32'hAA22CC44.
REQ-024 Read wb_adr=200 -> with WB_RESP_ERR_EN: wb_err pulse, data 0; without: wb_ack, data = mem[72].
REQ-025 WAIT_STATES=3, drop wb_cyc in the 2nd wait cycle of a write -> no ack/err, memory unchanged; the next read is normal.
REQ-026 Bus write 32'h1 and preload 32'h2 to word 7 on the same edge -> mem[7]=32'h2; a read of word 7 in the same cycle returns the prior value.
REQ-027 Assert reset in WAIT of a write to word 9 -> ack/err/dat low immediately, mem[9] unchanged, the next request is accepted normally.
